// File: rtl/ddr2_init_pkg.sv
// Shared definitions for the DDR2 power-up/initialization sequencer:
// command encodings, FSM states, step indices and address bit positions.
package ddr2_init_pkg;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  typedef enum logic [2:0] {
    PWRUP_WAIT = 3'd0,
    XPR_WAIT   = 3'd1,
    ISSUE      = 3'd2,
    GAP_WAIT   = 3'd3,
    DLL_WAIT   = 3'd4,
    DONE       = 3'd5
  } state_t;

  // Step index of the next command to issue; STEP_END marks the post-OCD-exit tMRD
  localparam logic [3:0] STEP_PRE0     = 4'd0;
  localparam logic [3:0] STEP_EMR2     = 4'd1;
  localparam logic [3:0] STEP_EMR3     = 4'd2;
  localparam logic [3:0] STEP_EMR1     = 4'd3;
  localparam logic [3:0] STEP_MR_DLL   = 4'd4;
  localparam logic [3:0] STEP_PRE1     = 4'd5;
  localparam logic [3:0] STEP_REF0     = 4'd6;
  localparam logic [3:0] STEP_REF1     = 4'd7;
  localparam logic [3:0] STEP_MR       = 4'd8;
  localparam logic [3:0] STEP_OCD_DEF  = 4'd9;
  localparam logic [3:0] STEP_OCD_EXIT = 4'd10;
  localparam logic [3:0] STEP_END      = 4'd11;

  localparam int A10_BIT = 10;
  localparam int A9_BIT  = 9;
  localparam int A8_BIT  = 8;
  localparam int A7_BIT  = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr2_init_sequencer_if.sv
// DDR2 command bus plus init handshake between the sequencer (master) and
// the memory/controller side (slave).
interface ddr2_init_sequencer_if #(
  parameter int ROW_ADDR_WIDTH = 13,
  parameter int BANK_WIDTH     = 2
);
  // cmd_valid is a pure strobe with no ready: it is high for exactly the one
  // cycle a non-NOP command sits on the bus and the memory must accept it.
  // reinit_req is a one-cycle pulse, acted on only while init_done is high.
  logic                      reinit_req;
  logic                      cke;
  logic                      cs_n;
  logic                      ras_n;
  logic                      cas_n;
  logic                      we_n;
  logic [ROW_ADDR_WIDTH-1:0] addr;
  logic [BANK_WIDTH-1:0]     ba;
  logic                      cmd_valid;
  logic                      init_done;

  modport master (
    input  reinit_req,
    output cke, cs_n, ras_n, cas_n, we_n, addr, ba, cmd_valid, init_done
  );

  modport slave (
    output reinit_req,
    input  cke, cs_n, ras_n, cas_n, we_n, addr, ba, cmd_valid, init_done
  );
endinterface

// File: rtl/ddr2_init_timer.sv
// Loadable saturating down-counter; zero_o is high while the count is zero.
// A load of N-1 on cycle t makes zero_o visible to the next-state logic at t+N.
module ddr2_init_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_0,
  input  logic             rst_tmp,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk_0 or posedge rst_tmp) begin
    if (rst_tmp) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/ddr2_init_sequencer.sv
// JEDEC DDR2 power-up and initialization sequencer. Owns the command bus
// until init_done, then drives NOP with cke high until a reinit request.
module ddr2_init_sequencer
  import ddr2_init_pkg::*;
#(
  parameter int ROW_ADDR_WIDTH    = 13,
  parameter int BANK_WIDTH        = 2,
  parameter int WAIT_PWRUP_CYCLES = 40000,
  parameter int T_XPR_CYCLES      = 80,
  parameter int T_RP_CYCLES       = 4,
  parameter int T_MRD_CYCLES      = 2,
  parameter int T_RFC_CYCLES      = 26,
  parameter int DLL_LOCK_CYCLES   = 200,
  parameter logic [ROW_ADDR_WIDTH-1:0] MR_VALUE   = 13'h0442,
  parameter logic [ROW_ADDR_WIDTH-1:0] EMR1_VALUE = 13'h0004
) (
  input  logic                  clk_0,
  input  logic                  rst_tmp,
  ddr2_init_sequencer_if.master bus,
  output state_t                dbg_state_o
);

  localparam int MAX_T = max_int(max_int(max_int(WAIT_PWRUP_CYCLES, T_XPR_CYCLES),
                                         max_int(T_RP_CYCLES, T_MRD_CYCLES)),
                                 max_int(T_RFC_CYCLES, DLL_LOCK_CYCLES));
  localparam int CW = $clog2(MAX_T) + 1;

  // Every timer is loaded with (interval - 1); see ddr2_init_timer
  localparam logic [CW-1:0] LD_PWRUP = CW'(WAIT_PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_XPR   = CW'(T_XPR_CYCLES - 1);
  localparam logic [CW-1:0] LD_RP    = CW'(T_RP_CYCLES - 1);
  localparam logic [CW-1:0] LD_MRD   = CW'(T_MRD_CYCLES - 1);
  localparam logic [CW-1:0] LD_RFC   = CW'(T_RFC_CYCLES - 1);
  localparam logic [CW-1:0] LD_DLL   = CW'(DLL_LOCK_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [3:0]                step_q, step_d;
  logic                      armed_q, armed_d;
  logic                      cke_q, cke_d;
  logic                      cs_n_q;
  logic [2:0]                cmd_q, cmd_d;
  logic [ROW_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BANK_WIDTH-1:0]     ba_q, ba_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      init_done_q, init_done_d;

  logic                      gap_load, gap_zero;
  logic [CW-1:0]             gap_val;
  logic                      dll_load, dll_zero;
  logic                      issue;
  logic                      can_issue;

  logic [2:0]                sel_cmd;
  logic [ROW_ADDR_WIDTH-1:0] sel_addr;
  logic [BANK_WIDTH-1:0]     sel_ba;
  logic [CW-1:0]             sel_gap;

  ddr2_init_timer #(.WIDTH(CW)) u_gap_timer (
    .clk_0      (clk_0),
    .rst_tmp    (rst_tmp),
    .load_i     (gap_load),
    .load_val_i (gap_val),
    .zero_o     (gap_zero)
  );

  ddr2_init_timer #(.WIDTH(CW)) u_dll_timer (
    .clk_0      (clk_0),
    .rst_tmp    (rst_tmp),
    .load_i     (dll_load),
    .load_val_i (LD_DLL),
    .zero_o     (dll_zero)
  );

  // Command, bank, address and following spacing for the step about to issue
  always_comb begin
    sel_cmd  = CMD_NOP;
    sel_addr = '0;
    sel_ba   = '0;
    sel_gap  = LD_MRD;
    case (step_q)
      STEP_PRE0, STEP_PRE1: begin
        sel_cmd          = CMD_PRE;
        sel_addr[A10_BIT] = 1'b1;
        sel_gap          = LD_RP;
      end
      STEP_EMR2: begin
        sel_cmd = CMD_LMR;
        sel_ba  = BANK_WIDTH'(2);
      end
      STEP_EMR3: begin
        sel_cmd = CMD_LMR;
        sel_ba  = BANK_WIDTH'(3);
      end
      STEP_EMR1, STEP_OCD_EXIT: begin
        sel_cmd                  = CMD_LMR;
        sel_ba                   = BANK_WIDTH'(1);
        sel_addr                 = EMR1_VALUE;
        sel_addr[A9_BIT:A7_BIT] = 3'b000;
      end
      STEP_MR_DLL: begin
        sel_cmd          = CMD_LMR;
        sel_addr         = MR_VALUE;
        sel_addr[A8_BIT] = 1'b1;
      end
      STEP_REF0, STEP_REF1: begin
        sel_cmd = CMD_REF;
        sel_gap = LD_RFC;
      end
      STEP_MR: begin
        sel_cmd          = CMD_LMR;
        sel_addr         = MR_VALUE;
        sel_addr[A8_BIT] = 1'b0;
      end
      STEP_OCD_DEF: begin
        sel_cmd                  = CMD_LMR;
        sel_ba                   = BANK_WIDTH'(1);
        sel_addr                 = EMR1_VALUE;
        sel_addr[A9_BIT:A7_BIT] = 3'b111;
      end
      default: begin
      end
    endcase
  end

  // OCD-default additionally waits for the DLL lock interval
  assign can_issue = gap_zero && ((step_q != STEP_OCD_DEF) || dll_zero);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    armed_d     = armed_q;
    cke_d       = cke_q;
    cmd_d       = CMD_NOP;
    addr_d      = '0;
    ba_d        = '0;
    cmd_valid_d = 1'b0;
    init_done_d = init_done_q;
    gap_load    = 1'b0;
    gap_val     = sel_gap;
    dll_load    = 1'b0;
    issue       = 1'b0;

    case (state_q)
      PWRUP_WAIT: begin
        // First cycle out of reset arms the power-up wait
        if (!armed_q) begin
          armed_d  = 1'b1;
          gap_load = 1'b1;
          gap_val  = LD_PWRUP;
        end else if (gap_zero) begin
          cke_d    = 1'b1;
          state_d  = XPR_WAIT;
          step_d   = STEP_PRE0;
          gap_load = 1'b1;
          gap_val  = LD_XPR;
        end
      end
      XPR_WAIT: begin
        if (gap_zero) begin
          issue = 1'b1;
        end
      end
      ISSUE, GAP_WAIT, DLL_WAIT: begin
        if (step_q == STEP_END) begin
          if (gap_zero) begin
            state_d     = DONE;
            init_done_d = 1'b1;
          end else begin
            state_d = GAP_WAIT;
          end
        end else if (can_issue) begin
          issue = 1'b1;
        end else if (gap_zero) begin
          state_d = DLL_WAIT;
        end else begin
          state_d = GAP_WAIT;
        end
      end
      DONE: begin
        // Zero-length XPR_WAIT puts the PRE-all one cycle after init_done drops
        if (bus.reinit_req) begin
          init_done_d = 1'b0;
          state_d     = XPR_WAIT;
          step_d      = STEP_PRE0;
          gap_load    = 1'b1;
          gap_val     = '0;
        end
      end
      default: begin
        state_d = PWRUP_WAIT;
      end
    endcase

    if (issue) begin
      state_d     = ISSUE;
      cmd_d       = sel_cmd;
      addr_d      = sel_addr;
      ba_d        = sel_ba;
      cmd_valid_d = 1'b1;
      gap_load    = 1'b1;
      gap_val     = sel_gap;
      step_d      = step_q + 4'd1;
      dll_load    = (step_q == STEP_MR_DLL);
    end
  end

  always_ff @(posedge clk_0 or posedge rst_tmp) begin
    if (rst_tmp) begin
      state_q     <= PWRUP_WAIT;
      step_q      <= STEP_PRE0;
      armed_q     <= 1'b0;
      cke_q       <= 1'b0;
      cs_n_q      <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      ba_q        <= '0;
      cmd_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      armed_q     <= armed_d;
      cke_q       <= cke_d;
      cs_n_q      <= 1'b0;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      ba_q        <= ba_d;
      cmd_valid_q <= cmd_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.cke       = cke_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.ras_n     = cmd_q[2];
  assign bus.cas_n     = cmd_q[1];
  assign bus.we_n      = cmd_q[0];
  assign bus.addr      = addr_q;
  assign bus.ba        = ba_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.init_done = init_done_q;
  assign dbg_state_o   = state_q;

endmodule
